// File: rtl/cond_unit.sv
// Conditional-execution stage: holds the architectural {N,Z,C,V} flags, evaluates the
// instruction condition field against them and gates PC/register/memory write enables.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       flags_r;
    logic [3:0]       flags_nxt_s;
    logic [CNT_W-1:0] exec_cnt_r;
    logic [CNT_W-1:0] exec_nxt_s;
    logic [CNT_W-1:0] squash_cnt_r;
    logic [CNT_W-1:0] squash_nxt_s;
    logic             cond_ex_s;
    logic             go_s;
    logic             commit_s;
    logic             squash_s;

    // f = {N,Z,C,V}; the reserved encoding 4'b1111 never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Condition evaluation against held flags and the commit/squash qualifiers.
    always_comb begin
        cond_ex_s = cond_pass(Cond, flags_r);
        go_s      = valid_i & en & ~flush;
        commit_s  = go_s & cond_ex_s;
        squash_s  = go_s & ~cond_ex_s;
    end

    assign CondEx     = cond_ex_s;
    assign PCSrc      = commit_s & PCS;
    assign RegWrite   = commit_s & RegW & ~NoWrite;
    assign MemWrite   = commit_s & MemW;
    assign Flags      = flags_r;
    assign exec_cnt   = exec_cnt_r;
    assign squash_cnt = squash_cnt_r;

    // Next flag value: each FlagW bit independently selects its flag pair.
    always_comb begin
        flags_nxt_s = flags_r;
        if (commit_s) begin
            if (FlagW[1]) begin
                flags_nxt_s[3:2] = ALUFlags[3:2];
            end else begin
                flags_nxt_s[3:2] = flags_r[3:2];
            end
            if (FlagW[0]) begin
                flags_nxt_s[1:0] = ALUFlags[1:0];
            end else begin
                flags_nxt_s[1:0] = flags_r[1:0];
            end
        end else begin
            flags_nxt_s = flags_r;
        end
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        exec_nxt_s   = exec_cnt_r;
        squash_nxt_s = squash_cnt_r;
        if (cnt_clr) begin
            exec_nxt_s   = CNT_ZERO;
            squash_nxt_s = CNT_ZERO;
        end else begin
            if (commit_s && (exec_cnt_r != CNT_MAX)) begin
                exec_nxt_s = exec_cnt_r + CNT_ONE;
            end else begin
                exec_nxt_s = exec_cnt_r;
            end
            if (squash_s && (squash_cnt_r != CNT_MAX)) begin
                squash_nxt_s = squash_cnt_r + CNT_ONE;
            end else begin
                squash_nxt_s = squash_cnt_r;
            end
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_cnt_r   <= CNT_ZERO;
            squash_cnt_r <= CNT_ZERO;
        end else begin
            exec_cnt_r   <= exec_nxt_s;
            squash_cnt_r <= squash_nxt_s;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed table, exhaustive decode sweep,
// reset/saturation sequences and randomized traffic against a reference model.
module tb_cond_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             en;
    logic             flush;
    logic             valid_i;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             cnt_clr;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] squash_cnt;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .cnt_clr(cnt_clr), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] m_flags;
    int         m_exec;
    int         m_squash;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Conditions come in complementary pairs: odd encodings invert the even base test.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, ge, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        ge = (n == v);
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = ge;
            3'd6: base = !z && ge;
            default: base = 1'b1;
        endcase
        if (c == 4'd15) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic drive(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic rw, input logic mw, input logic nw,
                         input logic e, input logic fl, input logic v, input logic clr);
        Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
        NoWrite = nw; en = e; flush = fl; valid_i = v; cnt_clr = clr;
    endtask

    // One clocked instruction: checks outputs before and after the edge against the model.
    task automatic step(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                        input logic pcs, input logic rw, input logic mw, input logic nw,
                        input logic e, input logic fl, input logic v, input logic clr,
                        output logic o_cex, output logic o_pc, output logic o_rw,
                        output logic o_mw, output logic [3:0] o_flags);
        bit go, pass;
        @(negedge clk);
        drive(c, alu, fw, pcs, rw, mw, nw, e, fl, v, clr);
        #1;
        pass = ref_cond(c, m_flags);
        go   = v && e && !fl;
        o_cex = CondEx; o_pc = PCSrc; o_rw = RegWrite; o_mw = MemWrite;
        chk("CondEx", CondEx, pass);
        chk("PCSrc", PCSrc, go && pass && pcs);
        chk("RegWrite", RegWrite, go && pass && rw && !nw);
        chk("MemWrite", MemWrite, go && pass && mw);
        @(posedge clk);
        if (go && pass) begin
            if (fw[1]) m_flags[3:2] = alu[3:2];
            if (fw[0]) m_flags[1:0] = alu[1:0];
        end
        if (clr) begin
            m_exec = 0; m_squash = 0;
        end else if (go) begin
            if (pass) m_exec   = (m_exec   < CNT_MAX) ? m_exec + 1   : CNT_MAX;
            else      m_squash = (m_squash < CNT_MAX) ? m_squash + 1 : CNT_MAX;
        end
        #1;
        o_flags = Flags;
        chk("Flags", Flags, m_flags);
        chk("exec_cnt", exec_cnt, m_exec);
        chk("squash_cnt", squash_cnt, m_squash);
    endtask

    typedef struct {
        logic [3:0] cond; logic [3:0] alu; logic [1:0] fw;
        logic pcs; logic rw; logic mw; logic nw; logic e; logic fl; logic v;
        logic x_cex; logic x_pc; logic x_rw; logic x_mw; logic [3:0] x_flags;
    } vec_t;

    vec_t tbl[13];
    logic s_cex, s_pc, s_rw, s_mw;
    logic [3:0] s_fl;

    initial begin
        // cond alu fw pcs rw mw nw en fl v | cex pc rw mw flags_after
        tbl[0]  = '{4'b1110, 4'b0100, 2'b11, 0,0,0,0, 1,0,1, 1,0,0,0, 4'b0100};
        tbl[1]  = '{4'b0000, 4'b0000, 2'b00, 1,0,0,0, 1,0,1, 1,1,0,0, 4'b0100};
        tbl[2]  = '{4'b0001, 4'b0000, 2'b00, 1,0,0,0, 1,0,1, 0,0,0,0, 4'b0100};
        tbl[3]  = '{4'b1110, 4'b1010, 2'b11, 0,0,0,0, 1,0,1, 1,0,0,0, 4'b1010};
        tbl[4]  = '{4'b1110, 4'b0101, 2'b10, 0,0,0,0, 1,0,1, 1,0,0,0, 4'b0110};
        tbl[5]  = '{4'b1110, 4'b1000, 2'b11, 0,0,0,0, 1,0,1, 1,0,0,0, 4'b1000};
        tbl[6]  = '{4'b1011, 4'b0000, 2'b00, 0,1,0,0, 1,0,1, 1,0,1,0, 4'b1000};
        tbl[7]  = '{4'b1100, 4'b0000, 2'b00, 0,1,0,0, 1,0,1, 0,0,0,0, 4'b1000};
        tbl[8]  = '{4'b1110, 4'b0111, 2'b11, 0,1,0,0, 0,0,1, 1,0,0,0, 4'b1000};
        tbl[9]  = '{4'b1110, 4'b0111, 2'b11, 0,1,0,0, 1,1,1, 1,0,0,0, 4'b1000};
        tbl[10] = '{4'b1110, 4'b0111, 2'b11, 0,1,0,0, 1,0,0, 1,0,0,0, 4'b1000};
        tbl[11] = '{4'b1110, 4'b0011, 2'b11, 0,1,0,1, 1,0,1, 1,0,0,0, 4'b0011};
        tbl[12] = '{4'b0010, 4'b0000, 2'b00, 0,0,1,0, 1,0,1, 1,0,0,1, 4'b0011};

        drive(4'd0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        reset = 1'b0;
        #12;
        chk("reset_Flags", Flags, 4'b0000);
        chk("reset_exec", exec_cnt, 0);
        chk("reset_squash", squash_cnt, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].cond, tbl[i].alu, tbl[i].fw, tbl[i].pcs, tbl[i].rw, tbl[i].mw,
                 tbl[i].nw, tbl[i].e, tbl[i].fl, tbl[i].v, 1'b0, s_cex, s_pc, s_rw, s_mw, s_fl);
            chk($sformatf("tbl%0d_CondEx", i), s_cex, tbl[i].x_cex);
            chk($sformatf("tbl%0d_PCSrc", i), s_pc, tbl[i].x_pc);
            chk($sformatf("tbl%0d_RegWrite", i), s_rw, tbl[i].x_rw);
            chk($sformatf("tbl%0d_MemWrite", i), s_mw, tbl[i].x_mw);
            chk($sformatf("tbl%0d_Flags", i), s_fl, tbl[i].x_flags);
        end

        // Exhaustive condition decode over every held flag value (valid=0 keeps state).
        for (int f = 0; f < 16; f++) begin
            step(4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 1, 0, 1, 0, s_cex, s_pc, s_rw, s_mw, s_fl);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                drive(4'(c), 4'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
                #1;
                chk($sformatf("decode_c%0d_f%0d", c, f), CondEx, ref_cond(4'(c), 4'(f)));
                if (c == 15) chk("reserved_cond", CondEx, 1'b0);
            end
        end

        // Mid-stall asynchronous reset with Flags=1111 and exec_cnt=5.
        step(4'b1110, 4'd0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, s_cex, s_pc, s_rw, s_mw, s_fl);
        for (int i = 0; i < 5; i++)
            step(4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 1, 0, 1, 0, s_cex, s_pc, s_rw, s_mw, s_fl);
        chk("pre_reset_Flags", Flags, 4'b1111);
        chk("pre_reset_exec", exec_cnt, 5);
        @(negedge clk);
        drive(4'b0001, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_Flags", Flags, 4'b0000);
        chk("async_reset_exec", exec_cnt, 0);
        chk("async_reset_squash", squash_cnt, 0);
        chk("async_reset_CondEx_NE", CondEx, 1'b1);
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        @(negedge clk);
        reset = 1'b1;

        // Saturation: 17 executions land on the maximum, then clear beats an increment.
        for (int i = 0; i < 17; i++)
            step(4'b1110, 4'd0, 2'b00, 0, 1, 0, 0, 1, 0, 1, 0, s_cex, s_pc, s_rw, s_mw, s_fl);
        chk("exec_saturated", exec_cnt, CNT_MAX);
        step(4'b1110, 4'd0, 2'b00, 0, 1, 0, 0, 1, 0, 1, 1, s_cex, s_pc, s_rw, s_mw, s_fl);
        chk("clr_priority", exec_cnt, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 63) == 0), s_cex, s_pc, s_rw, s_mw, s_fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution and status-flag stage that sits directly downstream of the ALU. It consumes ALUFlags {N,Z,C,V} and holds them in the architectural flag register.
- Evaluates each instruction's 4-bit condition field against the currently held flags. Gates the PC, register-file and memory write enables accordingly.
- Keeps saturating counters of executed and squashed instructions for bring-up and performance debug.

Parameters:
- CNT_W, default 16: width of the exec_cnt and squash_cnt counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted = 0).
- en  input  1  stage advance; 0 = stall, no state update and all write enables forced to 0.
- flush  input  1  squash current instruction; no flag update, no writes, no count.
- valid_i  input  1  instruction present in this stage.
- Cond  input  4  instruction condition field [31:28].
- ALUFlags  input  4  from ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  input  2  [1] = update N,Z; [0] = update C,V.
- PCS  input  1  instruction writes PC.
- RegW  input  1  instruction writes register file.
- MemW  input  1  instruction writes memory.
- NoWrite  input  1  compare-type instruction; suppresses RegWrite.
- cnt_clr  input  1  synchronous clear of both counters.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition passed for the current instruction.
- Flags  output  4  registered {N,Z,C,V}.
- exec_cnt  output  CNT_W  executed-instruction count.
- squash_cnt  output  CNT_W  condition-failed instruction count.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall):
  - Flags=4'b0000, exec_cnt=0, squash_cnt=0.
  - Combinational outputs follow their equations using the reset Flags.
- Condition evaluation is combinational, zero latency, and uses the registered Flags only (never the same-cycle ALUFlags).
- Condition decode, with N,Z,C,V taken from Flags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL always 1; 1111 reserved, CondEx=0.
- go = valid_i & en & ~flush.
- Write enables:
  - PCSrc = go & CondEx & PCS
  - RegWrite = go & CondEx & RegW & ~NoWrite
  - MemWrite = go & CondEx & MemW
- Flag register, on the clock edge when go & CondEx:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - Bits not selected by FlagW hold. With no go, or CondEx=0, all bits hold.
- Back-to-back: a flag-setting instruction in cycle t affects the condition of the instruction in cycle t+1 (one-cycle visibility).
- Counters:
  - go & CondEx increments exec_cnt; go & ~CondEx increments squash_cnt.
  - Both saturate at 2^CNT_W-1; no wrap.
  - cnt_clr=1 zeroes both counters and has priority over a same-cycle increment.
  - cnt_clr does not affect Flags.
- Stall (en=0): write enables 0, Flags and counters hold, CondEx still reflects the current inputs.
- flush=1 while en=1: same as stall for one cycle.
- valid_i=0: same as a flushed cycle.

Test Plan:
- Reset: drive reset=0 mid-run with Flags=1111 and exec_cnt=5 -> Flags=0000 and both counters 0 immediately, without waiting for clk.
- Flag set then branch:
  - Cycle 1: valid, Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 after the edge.
  - Cycle 2: Cond=0000, PCS=1 -> CondEx=1, PCSrc=1.
  - Same cycle-2 sequence with Cond=0001 -> PCSrc=0, squash_cnt increments by 1.
- Partial update: Flags=1010, FlagW=10, ALUFlags=0101, AL -> Flags=0110 (C,V held).
- Signed compares:
  - Flags N=1, V=0: Cond=1011 (LT) -> RegWrite=RegW.
  - Same flags, Cond=1100 (GT) -> CondEx=0.
  - Cond=1111 -> CondEx=0 for every flag value.
- Stall/flush:
  - en=0 with AL, RegW=1, FlagW=11 -> RegWrite=0, Flags unchanged, counters unchanged.
  - flush=1 -> same result.
  - NoWrite=1, RegW=1, AL -> RegWrite=0, flags updated.
- Counters: CNT_W=4, 17 executed instructions -> exec_cnt=15 (saturated). cnt_clr asserted in the same cycle as an increment -> exec_cnt=0.
